// File: rtl/reaction_pkg.sv
// reaction_pkg: shared status encoding and BCD constants for the reaction-time core.
package reaction_pkg;
   typedef enum logic [2:0] {
      DST_IDLE  = 3'b000,
      DST_READY = 3'b001,
      DST_GO    = 3'b010,
      DST_MISS  = 3'b011,
      DST_HIT   = 3'b110
   } dst_e;
   localparam int          BCD_DIGITS = 6;
   localparam logic [23:0] BCD_MAX    = 24'h999999;
   localparam int          US_PER_MS  = 1000;
endpackage

// File: rtl/reaction_if.sv
// reaction_if: button/tick/select inputs and status/result outputs of the reaction core.
interface reaction_if;
   logic        i_btn;
   logic        i_tick_us;
   logic        i_bcdmux;
   logic [2:0]  o_dst;
   logic [23:0] o_bcd;
   logic        o_lit;
   logic        o_miss;
   logic        o_init;
   modport master (output i_btn, i_tick_us, i_bcdmux, input o_dst, o_bcd, o_lit, o_miss, o_init);
   modport slave  (input i_btn, i_tick_us, i_bcdmux, output o_dst, o_bcd, o_lit, o_miss, o_init);
endinterface

// File: rtl/reaction_bcd_counter.sv
// bcd_counter: N-digit saturating BCD incrementer with synchronous clear and enable.
import reaction_pkg::*;
module bcd_counter #(
   parameter int N = BCD_DIGITS
) (
   input  logic           i_clk,
   input  logic           i_rst_n,
   input  logic           i_clr,
   input  logic           i_en,
   output logic [4*N-1:0] o_cnt,
   output logic           o_sat
);
   logic [4*N-1:0] r_cnt;
   logic [4*N-1:0] w_nxt;
   logic           w_c;
   always_comb begin
      w_nxt = r_cnt;
      w_c   = i_en & ~o_sat;
      for (int i = 0; i < N; i++) begin
         w_nxt[4*i+:4] = w_c ? ((r_cnt[4*i+:4] == 4'd9) ? 4'd0 : r_cnt[4*i+:4] + 4'd1) : r_cnt[4*i+:4];
         w_c           = w_c & (r_cnt[4*i+:4] == 4'd9);
      end
   end
   always_ff @(posedge i_clk or negedge i_rst_n)
      if (!i_rst_n) r_cnt <= '0;
      else          r_cnt <= i_clr ? '0 : w_nxt;
   assign o_cnt = r_cnt;
   assign o_sat = (r_cnt == {N{4'h9}});
endmodule

// File: rtl/reaction_core.sv
// reaction_core: reaction-game FSM, LFSR delay, BCD stopwatch and last/best results.
// Define REACTION_LIVE_TIMER_EN to show the running stopwatch on the "last" line during GO.
import reaction_pkg::*;
module reaction_core #(
   parameter int          DELAY_MIN_MS    = 1000,
   parameter int          DELAY_SPAN_BITS = 11,
   parameter logic [15:0] LFSR_SEED       = 16'hACE1,
   parameter int          SW_DIGITS       = BCD_DIGITS
) (
   input logic       i_clk,
   input logic       i_rst_n,
   reaction_if.slave io
);
   localparam int DW = $clog2(DELAY_MIN_MS + (1 << DELAY_SPAN_BITS));
   dst_e                   r_state;
   logic                   r_btn, r_arm, r_lit, r_miss, r_init;
   logic [23:0]            r_last, r_best;
   logic [15:0]            r_lfsr;
   logic [DW-1:0]          r_delay;
   logic [9:0]             r_pre;
   logic [4*SW_DIGITS-1:0] w_sw;
   logic [23:0]            w_cap;
   logic                   w_sat, w_press, w_expire;
   // r_arm masks the first clock after reset so a button held through release is not a press
   assign w_press  = r_arm & io.i_btn & ~r_btn;
   assign w_expire = io.i_tick_us && (r_pre == 10'(US_PER_MS - 1)) && (r_delay == DW'(1));
   assign w_cap    = 24'(w_sw);
   bcd_counter #(.N(SW_DIGITS)) u_sw (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_clr   (r_state == DST_READY && w_expire),
      .i_en    (r_state == DST_GO && io.i_tick_us),
      .o_cnt   (w_sw),
      .o_sat   (w_sat)
   );
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= DST_IDLE;
         r_btn   <= 1'b0;
         r_arm   <= 1'b0;
         r_lit   <= 1'b0;
         r_miss  <= 1'b0;
         r_init  <= 1'b1;
         r_last  <= '0;
         r_best  <= '0;
         r_lfsr  <= LFSR_SEED;
         r_delay <= '0;
         r_pre   <= '0;
      end else begin
         r_btn  <= io.i_btn;
         r_arm  <= 1'b1;
         r_lfsr <= {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? 16'hB400 : 16'h0000);
         if (r_state == DST_READY && io.i_tick_us) begin
            r_pre <= (r_pre == 10'(US_PER_MS - 1)) ? 10'd0 : r_pre + 10'd1;
            if (r_pre == 10'(US_PER_MS - 1)) r_delay <= r_delay - DW'(1);
         end
         case (r_state)
            DST_IDLE, DST_HIT, DST_MISS:
               if (w_press) begin
                  r_state <= DST_READY;
                  r_miss  <= 1'b0;
                  r_pre   <= '0;
                  r_delay <= DW'(DELAY_MIN_MS) + DW'(r_lfsr[DELAY_SPAN_BITS-1:0]);
               end
            DST_READY:
               if (w_press) begin
                  r_state <= DST_MISS;
                  r_miss  <= 1'b1;
               end else if (w_expire) begin
                  r_state <= DST_GO;
                  r_lit   <= 1'b1;
               end
            DST_GO:
               // the capture is the pre-tick count, so press beats a same-cycle timeout
               if (w_press) begin
                  r_state <= DST_HIT;
                  r_lit   <= 1'b0;
                  r_last  <= w_cap;
                  r_init  <= 1'b0;
                  if (r_init || w_cap < r_best) r_best <= w_cap;
               end else if (w_sat && io.i_tick_us) begin
                  r_state <= DST_MISS;
                  r_lit   <= 1'b0;
                  r_miss  <= 1'b1;
               end
            default: r_state <= DST_IDLE;
         endcase
      end
   end
   assign io.o_dst  = r_state;
   assign io.o_lit  = r_lit;
   assign io.o_miss = r_miss;
   assign io.o_init = r_init;
`ifdef REACTION_LIVE_TIMER_EN
   assign io.o_bcd = io.i_bcdmux ? r_best : (r_state == DST_GO) ? w_cap : r_last;
`else
   assign io.o_bcd = io.i_bcdmux ? r_best : r_last;
`endif
endmodule
